// File: rtl/alu_op_sequencer.sv
// Issue stage in front of the ALU: registers operands, waits SETTLE cycles,
// captures the ALU result and offers it on a valid/ready response port.
module alu_op_sequencer #(
    parameter int N      = 4,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [N-1:0]     req_a,
    input  logic [N-1:0]     req_b,
    input  logic [1:0]       req_op,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic [1:0]       alu_c,
    input  logic [N-1:0]     alu_y,
    input  logic             alu_cout,
    input  logic [3:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [N-1:0]     rsp_y,
    output logic             rsp_cout,
    output logic [3:0]       rsp_flags,
    input  logic             sticky_clr,
    output logic [3:0]       sticky_flags,
    output logic [CNT_W-1:0] op_count
);

    if (SETTLE < 1) begin : g_bad_settle
        $fatal(1, "alu_op_sequencer: SETTLE must be >= 1");
    end

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_RESP
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [SW-1:0] cnt_q;
    logic          accept;
    logic          capture;

    always_comb begin
        req_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);
        accept    = req_valid && req_ready;
        capture   = (state_q == ST_SETTLE) && (cnt_q == '0);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_SETTLE;
            ST_SETTLE: if (capture) state_d = ST_RESP;
            ST_RESP: begin
                if (accept)         state_d = ST_SETTLE;
                else if (rsp_ready) state_d = ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Operand registers and settle counter; alu_* persist after completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_a <= '0;
            alu_b <= '0;
            alu_c <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            alu_a <= req_a;
            alu_b <= req_b;
            alu_c <= req_op;
            cnt_q <= SW'(SETTLE - 1);
        end else if ((state_q == ST_SETTLE) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_cout  <= 1'b0;
            rsp_flags <= '0;
            op_count  <= '0;
        end else if (capture) begin
            rsp_valid <= 1'b1;
            rsp_y     <= alu_y;
            rsp_cout  <= alu_cout;
            rsp_flags <= alu_flags;
            op_count  <= op_count + 1'b1;
        end else if ((state_q == ST_RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // A clear coinciding with a capture restarts accumulation from the new flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sticky_flags <= '0;
        end else if (capture) begin
            sticky_flags <= (sticky_clr ? 4'b0000 : sticky_flags) | alu_flags;
        end else if (sticky_clr) begin
            sticky_flags <= '0;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: SETTLE=1 instance for the main flow,
// SETTLE=3/CNT_W=4 instance for latency and counter wrap.
module tb_alu_op_sequencer;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic logic [N:0] alu_model(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic [1:0] op);
        case (op)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {1'b0, a} + {1'b0, ~b} + 5'd1;
            2'b10:   return {1'b0, a & b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // SETTLE=1 instance
    logic         rst1, req_valid1, req_ready1, rsp_valid1, rsp_ready1, sticky_clr1;
    logic [N-1:0] req_a1, req_b1, alu_a1, alu_b1, alu_y1, rsp_y1;
    logic [1:0]   req_op1, alu_c1;
    logic         alu_cout1, rsp_cout1;
    logic [3:0]   alu_flags1, rsp_flags1, sticky1, mflags1;
    logic [15:0]  op_count1;

    assign {alu_cout1, alu_y1} = alu_model(alu_a1, alu_b1, alu_c1);
    assign alu_flags1 = mflags1;

    alu_op_sequencer #(.N(N), .SETTLE(1), .CNT_W(16)) dut1 (
        .clk(clk), .reset(rst1),
        .req_valid(req_valid1), .req_ready(req_ready1),
        .req_a(req_a1), .req_b(req_b1), .req_op(req_op1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_c(alu_c1),
        .alu_y(alu_y1), .alu_cout(alu_cout1), .alu_flags(alu_flags1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_y(rsp_y1), .rsp_cout(rsp_cout1), .rsp_flags(rsp_flags1),
        .sticky_clr(sticky_clr1), .sticky_flags(sticky1), .op_count(op_count1)
    );

    // SETTLE=3, CNT_W=4 instance
    logic         rst3, req_valid3, req_ready3, rsp_valid3, rsp_ready3, sticky_clr3;
    logic [N-1:0] req_a3, req_b3, alu_a3, alu_b3, alu_y3, rsp_y3;
    logic [1:0]   req_op3, alu_c3;
    logic         alu_cout3, rsp_cout3;
    logic [3:0]   alu_flags3, rsp_flags3, sticky3;
    logic [3:0]   op_count3;

    assign {alu_cout3, alu_y3} = alu_model(alu_a3, alu_b3, alu_c3);
    assign alu_flags3 = 4'b0000;

    alu_op_sequencer #(.N(N), .SETTLE(3), .CNT_W(4)) dut3 (
        .clk(clk), .reset(rst3),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_a(req_a3), .req_b(req_b3), .req_op(req_op3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_c(alu_c3),
        .alu_y(alu_y3), .alu_cout(alu_cout3), .alu_flags(alu_flags3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_y(rsp_y3), .rsp_cout(rsp_cout3), .rsp_flags(rsp_flags3),
        .sticky_clr(sticky_clr3), .sticky_flags(sticky3), .op_count(op_count3)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic [3:0] flags;
        logic [3:0] y;
        logic       cout;
        logic [3:0] sticky;
    } vec_t;

    vec_t vecs[6];
    vec_t sv[3];

    // Called at a negedge with dut1 idle; returns at a negedge with dut1 idle.
    task automatic run_op1(input vec_t v, input logic clr_cap, input int exp_cnt);
        req_a1 = v.a; req_b1 = v.b; req_op1 = v.op; mflags1 = v.flags;
        req_valid1 = 1'b1;
        #1 check("req_ready_idle", req_ready1, 1);
        @(negedge clk);
        req_valid1 = 1'b0;
        check("alu_a", alu_a1, v.a);
        check("alu_b", alu_b1, v.b);
        check("alu_c", alu_c1, v.op);
        check("settle_rsp_valid", rsp_valid1, 0);
        check("settle_req_ready", req_ready1, 0);
        sticky_clr1 = clr_cap;
        @(negedge clk);
        sticky_clr1 = 1'b0;
        check("rsp_valid", rsp_valid1, 1);
        check("rsp_y", rsp_y1, v.y);
        check("rsp_cout", rsp_cout1, v.cout);
        check("rsp_flags", rsp_flags1, v.flags);
        check("sticky", sticky1, v.sticky);
        check("op_count", op_count1, exp_cnt);
        rsp_ready1 = 1'b1;
        @(negedge clk);
        rsp_ready1 = 1'b0;
        check("rsp_valid_drop", rsp_valid1, 0);
        check("alu_a_held", alu_a1, v.a);
    endtask

    task automatic run_op3(input logic [3:0] a, input logic [3:0] exp_y, input logic [3:0] exp_cnt);
        req_a3 = a; req_b3 = 4'd1; req_op3 = 2'b00;
        req_valid3 = 1'b1;
        @(negedge clk);
        req_valid3 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("s3_early_valid", rsp_valid3, 0);
            @(negedge clk);
        end
        check("s3_early_valid", rsp_valid3, 0);
        @(negedge clk);
        check("s3_rsp_valid", rsp_valid3, 1);
        check("s3_rsp_y", rsp_y3, exp_y);
        check("s3_op_count", op_count3, exp_cnt);
        rsp_ready3 = 1'b1;
        @(negedge clk);
        rsp_ready3 = 1'b0;
    endtask

    initial begin
        //          a      b      op     flags    y      cout  sticky
        vecs[0] = '{4'd3,  4'd5,  2'b00, 4'b0000, 4'd8,  1'b0, 4'b0000};
        vecs[1] = '{4'd9,  4'd8,  2'b00, 4'b0100, 4'd1,  1'b1, 4'b0100};
        vecs[2] = '{4'd12, 4'd5,  2'b01, 4'b0001, 4'd7,  1'b1, 4'b0101};
        vecs[3] = '{4'd6,  4'd3,  2'b10, 4'b0010, 4'd2,  1'b0, 4'b0111};
        vecs[4] = '{4'd6,  4'd3,  2'b11, 4'b0000, 4'd5,  1'b0, 4'b0111};
        vecs[5] = '{4'd15, 4'd1,  2'b00, 4'b1000, 4'd0,  1'b1, 4'b1111};
        sv[0]   = '{4'd1,  4'd1,  2'b00, 4'b0100, 4'd2,  1'b0, 4'b0100};
        sv[1]   = '{4'd2,  4'd3,  2'b00, 4'b0001, 4'd5,  1'b0, 4'b0101};
        sv[2]   = '{4'd4,  4'd4,  2'b01, 4'b1000, 4'd0,  1'b1, 4'b1000};

        rst1 = 1'b0; req_valid1 = 1'b0; rsp_ready1 = 1'b0; sticky_clr1 = 1'b0;
        req_a1 = '0; req_b1 = '0; req_op1 = '0; mflags1 = '0;
        rst3 = 1'b0; req_valid3 = 1'b0; rsp_ready3 = 1'b0; sticky_clr3 = 1'b0;
        req_a3 = '0; req_b3 = '0; req_op3 = '0;

        // reset state
        repeat (3) @(negedge clk);
        rst1 = 1'b1; rst3 = 1'b1;
        @(negedge clk);
        check("rst_req_ready", req_ready1, 1);
        check("rst_rsp_valid", rsp_valid1, 0);
        check("rst_alu_a", alu_a1, 0);
        check("rst_alu_b", alu_b1, 0);
        check("rst_alu_c", alu_c1, 0);
        check("rst_sticky", sticky1, 0);
        check("rst_op_count", op_count1, 0);
        check("rst3_req_ready", req_ready3, 1);
        check("rst3_op_count", op_count3, 0);

        // table-driven single ops
        for (int i = 0; i < 6; i++) run_op1(vecs[i], 1'b0, i + 1);

        // sticky clear alone, accumulate, then clear on a capture edge
        sticky_clr1 = 1'b1;
        @(negedge clk);
        sticky_clr1 = 1'b0;
        check("sticky_clr_alone", sticky1, 0);
        run_op1(sv[0], 1'b0, 7);
        run_op1(sv[1], 1'b0, 8);
        run_op1(sv[2], 1'b1, 9);

        // backpressure with a pending request behind it
        req_a1 = 4'd7; req_b1 = 4'd9; req_op1 = 2'b00; mflags1 = 4'b0010;
        req_valid1 = 1'b1;
        @(negedge clk);
        req_a1 = 4'd2; req_b1 = 4'd2;
        @(negedge clk);
        mflags1 = 4'b0000;
        check("bp_rsp_valid", rsp_valid1, 1);
        check("bp_rsp_y", rsp_y1, 0);
        check("bp_rsp_cout", rsp_cout1, 1);
        check("bp_op_count", op_count1, 10);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_valid", rsp_valid1, 1);
            check("bp_hold_y", rsp_y1, 0);
            check("bp_hold_flags", rsp_flags1, 4'b0010);
            check("bp_req_ready", req_ready1, 0);
            check("bp_alu_a", alu_a1, 7);
            check("bp_alu_b", alu_b1, 9);
        end
        rsp_ready1 = 1'b1;
        #1 check("bp_req_ready_release", req_ready1, 1);
        @(negedge clk);
        rsp_ready1 = 1'b0; req_valid1 = 1'b0;
        check("bp_next_valid_low", rsp_valid1, 0);
        check("bp_next_alu_a", alu_a1, 2);
        @(negedge clk);
        check("bp_next_valid", rsp_valid1, 1);
        check("bp_next_y", rsp_y1, 4);
        check("bp_next_count", op_count1, 11);
        check("bp_sticky", sticky1, 4'b1010);
        rsp_ready1 = 1'b1;
        @(negedge clk);
        rsp_ready1 = 1'b0;

        // asynchronous reset during SETTLE
        req_a1 = 4'd5; req_b1 = 4'd6; req_op1 = 2'b00; req_valid1 = 1'b1;
        @(negedge clk);
        req_valid1 = 1'b0;
        rst1 = 1'b0;
        #1;
        check("mid_rst_alu_a", alu_a1, 0);
        check("mid_rst_op_count", op_count1, 0);
        check("mid_rst_rsp_y", rsp_y1, 0);
        check("mid_rst_sticky", sticky1, 0);
        check("mid_rst_req_ready", req_ready1, 1);
        @(negedge clk);
        @(negedge clk);
        rst1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_op_count", op_count1, 0);
        check("post_rst_rsp_valid", rsp_valid1, 0);

        // SETTLE=3 latency and 4-bit counter wrap
        for (int i = 0; i < 16; i++) run_op3(4'(i), 4'(i + 1), 4'(i + 1));
        check("s3_wrap", op_count3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
